// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and helpers for the multi-port register file.
//   ZERO_ADDR    - hard-wired zero register address
//   DEF_DATA_W   - default register width
//   DEF_ADDR_W   - default address width
//   MAX_WR       - largest supported number of write ports
//   eff_write()  - picks the winning write port from a per-port hit vector
package grf_pkg;

    localparam int unsigned ZERO_ADDR  = 0;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned MAX_WR     = 8;
    localparam int unsigned WR_IDX_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [WR_IDX_W-1:0] port;
    } eff_wr_t;

    // Highest-index set bit wins: later iterations overwrite earlier ones.
    function automatic eff_wr_t eff_write(input logic [MAX_WR-1:0] hit);
        eff_wr_t res;
        res.valid = 1'b0;
        res.port  = '0;
        for (int j = 0; j < int'(MAX_WR); j++) begin
            if (hit[j]) begin
                res.valid = 1'b1;
                res.port  = WR_IDX_W'(j);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: one pending bit per register plus an incrementally
// maintained count of pending registers.
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   wr_eff_i     - per-register effective write this cycle (bit 0 ignored)
//   iss_i        - per-register issue decode this cycle (bit 0 ignored)
//   pend_o       - pending bits
//   busy_count_o - number of pending registers
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [(1<<ADDR_W)-1:0]   wr_eff_i,
    input  logic [(1<<ADDR_W)-1:0]   iss_i,
    output logic [(1<<ADDR_W)-1:0]   pend_o,
    output logic [ADDR_W:0]          busy_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  busy_q, busy_d;
    logic [ADDR_W:0]  set_cnt_s, clr_cnt_s;

    // Next pending state: issue is applied after the clear so a same-cycle
    // issue (younger producer) keeps the bit set; count follows the edges.
    always_comb begin
        pend_d            = (pend_q & ~wr_eff_i) | iss_i;
        pend_d[ZERO_ADDR] = 1'b0;
        set_cnt_s         = '0;
        clr_cnt_s         = '0;
        for (int a = 0; a < DEPTH; a++) begin
            set_cnt_s = set_cnt_s + {{ADDR_W{1'b0}}, (pend_d[a] & ~pend_q[a])};
            clr_cnt_s = clr_cnt_s + {{ADDR_W{1'b0}}, (pend_q[a] & ~pend_d[a])};
        end
        busy_d = busy_q + set_cnt_s - clr_cnt_s;
    end

    // Pending bits and busy counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            busy_q <= '0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

    assign pend_o       = pend_q;
    assign busy_count_o = busy_q;

endmodule

// File: rtl/grf_mp.sv
// grf_mp: multi-port register file with write-through bypass and a pending
// scoreboard for operand readiness.
//   clk, reset  - rising-edge clock, asynchronous active-low reset
//   rd_addr     - NUM_RD read addresses          rd_data  - read data
//   rd_ready    - operand valid per read port
//   wr_en/addr/data/pc - NUM_WR write-back ports, higher index wins
//   iss_en/iss_addr    - destination of an issuing instruction
//   busy_count  - number of pending registers
module grf_mp
    import grf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int TRACE  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*32-1:0]       wr_pc,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]   wr_data_s   [NUM_WR];
    logic [ADDR_W-1:0]   wr_addr_s   [NUM_WR];
    logic [DATA_W-1:0]   wdata_eff_s [DEPTH];
    logic [WR_IDX_W-1:0] eff_port_s  [DEPTH];
    logic [DEPTH-1:0]    wr_eff_s;
    logic [DEPTH-1:0]    iss_dec_s;
    logic [DEPTH-1:0]    pend_s;
    logic [DATA_W-1:0]   regs_q      [DEPTH];

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
        assign wr_data_s[j] = wr_data[j*DATA_W +: DATA_W];
        assign wr_addr_s[j] = wr_addr[j*ADDR_W +: ADDR_W];
    end

    // Per-address write arbitration and issue decode; address 0 never
    // takes a write or becomes pending.
    always_comb begin
        logic [MAX_WR-1:0] hit;
        eff_wr_t           e;
        for (int a = 0; a < DEPTH; a++) begin
            hit = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                hit[j] = wr_en[j] && (wr_addr_s[j] == ADDR_W'(a));
            end
            e              = eff_write(hit);
            wr_eff_s[a]    = e.valid;
            eff_port_s[a]  = e.port;
            wdata_eff_s[a] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                wdata_eff_s[a] = (e.port == WR_IDX_W'(j)) ? wr_data_s[j] : wdata_eff_s[a];
            end
            iss_dec_s[a] = iss_en && (iss_addr == ADDR_W'(a));
        end
        wr_eff_s[ZERO_ADDR]  = 1'b0;
        iss_dec_s[ZERO_ADDR] = 1'b0;
    end

    // Register array; entry 0 is only ever loaded by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_eff_s[a]) begin
                    regs_q[a] <= wdata_eff_s[a];
                end else begin
                    regs_q[a] <= regs_q[a];
                end
            end
        end
    end

    // Read ports with write-through bypass; a same-cycle write also makes
    // a pending operand ready.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (wr_eff_s[ra]) begin
                rd_data[i*DATA_W +: DATA_W] = wdata_eff_s[ra];
            end else if (ra == ADDR_W'(ZERO_ADDR)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
            end
            rd_ready[i] = ~pend_s[ra] | wr_eff_s[ra];
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .wr_eff_i     (wr_eff_s),
        .iss_i        (iss_dec_s),
        .pend_o       (pend_s),
        .busy_count_o (busy_count)
    );

`ifndef SYNTHESIS
    if (TRACE != 0) begin : g_trace
        // Write trace in ascending port order; dropped and $0 writes are
        // filtered out by the effective-write decode.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_eff_s[wr_addr_s[j]] && (eff_port_s[wr_addr_s[j]] == WR_IDX_W'(j))) begin
                        $display("%d@%h: $%d <= %h", $time, wr_pc[j*32 +: 32],
                                 wr_addr_s[j], wr_data_s[j]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_mp.sv
module tb_grf_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_ready;
    logic [NW-1:0]     wr_en = '0;
    logic [NW*AW-1:0]  wr_addr = '0;
    logic [NW*DW-1:0]  wr_data = '0;
    logic [NW*32-1:0]  wr_pc = '0;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic [AW:0]       busy_count;

    always #5 clk = ~clk;

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .TRACE(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ready(rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_pc(wr_pc), .iss_en(iss_en), .iss_addr(iss_addr), .busy_count(busy_count)
    );

    typedef struct {
        int          kind;   // 0 data, 1 ready, 2 busy_count
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_regs [32];
    bit          ref_pend [32];

    function automatic logic [31:0] obs_of(int kind, int port);
        case (kind)
            0:       return rd_data[port*DW +: DW];
            1:       return {31'd0, rd_ready[port]};
            default: return {26'd0, busy_count};
        endcase
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            ref_regs[a] = 32'd0;
            ref_pend[a] = 1'b0;
        end
    endtask

    task automatic clr_in();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_pc = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic set_rd(int i, int a);
        rd_addr[i*AW +: AW] = a[4:0];
    endtask

    task automatic set_wr(int j, int a, logic [31:0] d);
        wr_en[j]             = 1'b1;
        wr_addr[j*AW +: AW]  = a[4:0];
        wr_data[j*DW +: DW]  = d;
        wr_pc[j*32 +: 32]    = 32'h0000_3000 + 32'(j * 4);
    endtask

    task automatic set_iss(int a);
        iss_en   = 1'b1;
        iss_addr = a[4:0];
    endtask

    // Push the expected combinational outputs for the inputs now applied.
    task automatic predict();
        logic [4:0]  a;
        logic [31:0] v;
        logic        r;
        int          cnt;
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            v = ref_regs[a];
            r = (a == 5'd0) || !ref_pend[a];
            if (a != 5'd0) begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                        v = wr_data[j*DW +: DW];
                        r = 1'b1;
                    end
                end
            end else begin
                v = 32'd0;
            end
            exp_q.push_back('{0, i, v});
            exp_q.push_back('{1, i, {31'd0, r}});
        end
        cnt = 0;
        for (int k = 0; k < 32; k++) cnt += int'(ref_pend[k]);
        exp_q.push_back('{2, 0, 32'(cnt)});
    endtask

    // Advance one clock; model state follows the inputs seen at the edge.
    task automatic tick();
        bit wrote [32];
        logic [4:0] wa;
        @(posedge clk);
        if (reset) begin
            for (int a = 0; a < 32; a++) wrote[a] = 1'b0;
            for (int j = 0; j < NW; j++) begin
                wa = wr_addr[j*AW +: AW];
                if (wr_en[j] && wa != 5'd0) begin
                    ref_regs[wa] = wr_data[j*DW +: DW];
                    wrote[wa]    = 1'b1;
                end
            end
            for (int a = 0; a < 32; a++) if (wrote[a]) ref_pend[a] = 1'b0;
            if (iss_en && iss_addr != 5'd0) ref_pend[iss_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            clr_in();
            case (s)
                0: ;
                1: begin reset = 1'b1; set_wr(0, 5, 32'h1234); set_iss(6); end
                2: begin set_rd(0, 5); set_rd(1, 6); #2; reset = 1'b0; model_reset(); end
                default: begin reset = 1'b1; set_rd(0, 5); end
            endcase
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL reset s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            if (s == 2) begin
                total++;
                if (rd_data !== '0 || rd_ready !== 2'b11 || busy_count !== 6'd0) begin
                    bad++;
                    $display("FAIL reset_async: got data=%h rdy=%b busy=%0d want 0/11/0", rd_data, rd_ready, busy_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_same_addr();
        for (int s = 0; s < 2; s++) begin
            clr_in();
            set_rd(0, 3);
            if (s == 0) begin set_wr(0, 3, 32'hAAAA); set_wr(1, 3, 32'hBBBB); end
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL same_addr s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            total++;
            if (rd_data[DW-1:0] !== 32'hBBBB) begin
                bad++;
                $display("FAIL same_addr_prio s%0d: got %h want 0000bbbb", s, rd_data[DW-1:0]);
            end
            tick();
        end
    endtask

    task automatic test_issue_hold();
        for (int s = 0; s < 6; s++) begin
            clr_in();
            set_rd(0, 7);
            if (s == 0) set_iss(7);
            if (s == 4) set_wr(0, 7, 32'h77);
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL issue_hold s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            if (s >= 1 && s <= 3) begin
                total++;
                if (rd_ready[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL issue_hold_stall s%0d: got %b want 0", s, rd_ready[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_issue_write_same();
        for (int s = 0; s < 2; s++) begin
            clr_in();
            set_rd(0, 9);
            if (s == 0) begin set_iss(9); set_wr(1, 9, 32'h99); end
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL iss_wr_same s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            if (s == 1) begin
                total++;
                if (rd_ready[0] !== 1'b0 || busy_count !== 6'd1) begin
                    bad++;
                    $display("FAIL iss_wr_same_pend: got rdy=%b busy=%0d want 0/1", rd_ready[0], busy_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero();
        for (int s = 0; s < 2; s++) begin
            clr_in();
            set_rd(0, 0);
            set_rd(1, 0);
            if (s == 0) begin set_wr(0, 0, 32'hFFFF); set_wr(1, 0, 32'hFFFF); set_iss(0); end
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL zero_reg s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        // s0 clears $9, s1..31 issue $1..$31, s32..47 drain two per cycle.
        for (int s = 0; s < 50; s++) begin
            clr_in();
            set_rd(0, 31);
            set_rd(1, 1);
            if (s == 0) set_wr(0, 9, 32'h9);
            else if (s <= 31) set_iss(s);
            else if (s <= 47) begin
                set_wr(0, 2*(s-32)+1, 32'h100 + 32'(s));
                if (2*(s-32)+2 <= 31) set_wr(1, 2*(s-32)+2, 32'h200 + 32'(s));
            end
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL fill_drain s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            if (s == 32 || s == 47 || s == 48) begin
                total++;
                if (busy_count !== ((s == 32) ? 6'd31 : (s == 47) ? 6'd1 : 6'd0)) begin
                    bad++;
                    $display("FAIL fill_drain_count s%0d: got %0d", s, busy_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 40; s++) begin
            clr_in();
            set_rd(0, int'($urandom_range(0, 7)));
            set_rd(1, int'($urandom_range(0, 7)));
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) == 1) set_wr(j, int'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 2) == 0) set_iss(int'($urandom_range(0, 7)));
            predict();
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_of(e.kind, e.port) !== e.val) begin
                    bad++;
                    $display("FAIL back_to_back s%0d k%0d p%0d: got %h want %h", s, e.kind, e.port, obs_of(e.kind, e.port), e.val);
                end
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_same_addr();
        test_issue_hold();
        test_issue_write_same();
        test_zero();
        test_fill_drain();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
